// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        GAP,
        HOLD
    } arb_state_t;

    localparam int DEF_N_REQ    = 3;
    localparam int DEF_GAP_CYC  = 16;
    localparam int DEF_LOCK_TMO = 4096;

    // Cycles the transmitter gets to raise busy after a load strobe.
    localparam int START_TMO = 4;

    function automatic logic [13:0] baud_div(input logic [2:0] code);
        logic [13:0] div;
        case (code)
            3'd0:    div = 14'd2603;
            3'd1:    div = 14'd10415;
            3'd2:    div = 14'd5207;
            3'd3:    div = 14'd2603;
            3'd4:    div = 14'd1301;
            3'd5:    div = 14'd650;
            3'd6:    div = 14'd433;
            default: div = 14'd216;
        endcase
        return div;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        return {oh[2] | oh[3], oh[1] | oh[3]};
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: lowest requesting index at or after ptr, wrapping to index 0.
module uart_rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] pick
);

    logic [N_REQ-1:0] above;
    logic [N_REQ-1:0] hi;
    logic [N_REQ-1:0] sel;

    always_comb begin
        above = ~((N_REQ'(1) << ptr) - N_REQ'(1));
        hi    = req & above;
        sel   = (hi != '0) ? hi : req;
        // Isolate the lowest set bit of the chosen window.
        pick  = sel & (~sel + N_REQ'(1));
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates byte requesters onto a single UART transmitter with message locking,
// inter-byte gap enforcement and lock/start timeouts.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no owner; pick round-robin once transmitter is free
// LOAD       | present owner byte, strobe tx_int and req_ready
// WAIT_START | wait up to START_TMO cycles for tx_busy to rise
// WAIT_DONE  | frame in flight, wait for tx_busy to fall
// GAP        | enforce GAP_CYC idle cycles, then release/continue/hold
// HOLD       | owner keeps grant awaiting its next byte, bounded by LOCK_TMO
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int GAP_CYC  = DEF_GAP_CYC,
    parameter int LOCK_TMO = DEF_LOCK_TMO
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_dat,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_dat,
    output logic               tx_int,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               lock_err
);

    localparam int CNT_A   = (LOCK_TMO > GAP_CYC) ? LOCK_TMO : GAP_CYC;
    localparam int CNT_MAX = (CNT_A > START_TMO) ? CNT_A : START_TMO;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(LOCK_TMO - 1);
    localparam logic [CW-1:0] START_LD = CW'(START_TMO - 1);
    localparam logic [1:0]    LAST_IDX = 2'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic [7:0]       dat_q, dat_d;

    logic [N_REQ-1:0] pick;
    logic [1:0]       pick_idx;
    logic [31:0]      dat_pad;
    logic [3:0]       valid_pad;
    logic [3:0]       last_pad;
    logic [7:0]       owner_byte;
    logic             owner_valid;
    logic [1:0]       next_ptr;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .pick (pick)
    );

    // Pad to four requesters so owner indexing stays width-clean for any N_REQ.
    assign dat_pad     = 32'(req_dat);
    assign valid_pad   = 4'(req_valid);
    assign last_pad    = 4'(req_last);
    assign pick_idx    = onehot_to_idx(4'(pick));
    assign owner_byte  = dat_pad[{owner_q, 3'b000} +: 8];
    assign owner_valid = valid_pad[owner_q];
    assign next_ptr    = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        lock_d  = lock_q;
        dat_d   = dat_q;

        case (state_q)
            IDLE: begin
                if (!tx_busy && (req_valid != '0)) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dat_d   = owner_byte;
                last_d  = last_pad[owner_q];
                cnt_d   = START_LD;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == '0) begin
                    lock_d  = 1'b1;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (last_q) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else if (owner_valid) begin
                    // Streaming owner skips HOLD to keep byte spacing tight.
                    state_d = LOAD;
                end else begin
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (owner_valid) begin
                    state_d = LOAD;
                end else if (cnt_q == '0) begin
                    lock_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_int    = (state_q == LOAD);
    assign req_ready = tx_int ? grant_q : '0;
    assign tx_dat    = tx_int ? owner_byte : dat_q;
    assign grant     = grant_q;
    assign lock_err  = lock_q;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 3: number of byte requesters, range 2..4.
REQ-002 Parameter GAP_CYC, default 16: idle clk cycles enforced between consecutive bytes.
REQ-003 Parameter LOCK_TMO, default 4096: max clk cycles a locked owner may stall before its grant is revoked.
REQ-004 Port clk, input, 1: single 25 MHz clock; all state on rising edge.
REQ-005 Port rstn, input, 1: asynchronous active-low reset.
REQ-006 Port req_valid, input, N_REQ: requester i has a byte on req_dat[8i+7:8i].
REQ-007 Port req_dat, input, 8*N_REQ: requester bytes, packed.
REQ-008 Port req_last, input, N_REQ: byte is final byte of requester's message.
REQ-009 Port req_ready, output, N_REQ: one-cycle byte-accept strobe.
REQ-010 Port tx_dat, output, 8: byte to UART transmitter.
REQ-011 Port tx_int, output, 1: one-cycle load strobe to UART transmitter.
REQ-012 Port tx_busy, input, 1: UART transmitter busy, high from cycle after tx_int until frame complete.
REQ-013 Port grant, output, N_REQ: one-hot current owner, 0 when none.
REQ-014 Port lock_err, output, 1: sticky; set on lock timeout or missing busy response.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, WAIT_START, WAIT_DONE, GAP, HOLD.
REQ-016 IDLE: when tx_busy==0 and any req_valid, pick owner round-robin starting at pointer ptr, set grant, go LOAD; else stay.
REQ-017 LOAD (1 cycle): capture owner's byte into tx_dat, assert tx_int and req_ready[owner], latch req_last into last_q, go WAIT_START.
REQ-018 Transfer SHALL occur only in LOAD; requester holds req_valid/req_dat/req_last stable until req_ready.
REQ-019 WAIT_START: on tx_busy==1 go WAIT_DONE; if not seen within 4 cycles, set lock_err and go GAP.
REQ-020 WAIT_DONE: on tx_busy==0 go GAP.
REQ-021 GAP: count GAP_CYC cycles; then if last_q==1 release (grant=0, ptr=owner+1 mod N_REQ) and go IDLE; else go HOLD.
REQ-022 HOLD: grant kept; if req_valid[owner] go LOAD; other requesters SHALL NOT be served.
REQ-023 HOLD counter reaching LOCK_TMO without req_valid[owner]: set lock_err, release as in REQ-021, go IDLE.
REQ-024 Byte-to-byte latency from LOAD to next LOAD for a streaming owner SHALL be frame time + GAP_CYC + 2 cycles.
REQ-025 Simultaneous requests: lowest index at or after ptr (wrapping) wins; ptr wraps N_REQ-1 to 0.
REQ-026 req_valid dropping in IDLE before selection: no grant, no strobe.
REQ-027 tx_dat SHALL hold its value from LOAD until the next LOAD.
REQ-028 grant SHALL never change outside IDLE entry or release; at most one bit set.

Reset
REQ-029 rstn low SHALL immediately force state IDLE, grant=0, req_ready=0, tx_int=0, tx_dat=0, ptr=0, last_q=0, counters=0, lock_err=0.
REQ-030 Reset mid-frame SHALL NOT abort the UART frame in flight; first post-reset grant waits for tx_busy==0 (REQ-016).

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state enum, baud-code constants (0..7 -> 2603,10415,5207,2603,1301,650,433,216), and default parameter constants.
REQ-032 Round-robin selection SHALL be a combinational sub-module uart_rr_pick (inputs req, ptr; output one-hot pick).
REQ-033 Design SHALL connect directly to the existing uart_tx (tx_dat, tx_int, rdy->tx_busy).

Verification
REQ-034 Single request: req0 byte 0x55 last=1 -> tx_int once, tx_dat=0x55, req_ready[0] one pulse, grant back to 0 after GAP, ptr=1.
REQ-035 Contention: req0,req1,req2 all valid last=1 from reset -> bytes sent in order 0,1,2, each separated by >= GAP_CYC idle cycles.
REQ-036 Lock: req1 sends 0x01(last=0),0x02(last=1) while req0 valid -> both req1 bytes precede req0's byte.
REQ-037 Lock timeout: req2 sends last=0 then drops valid -> after LOCK_TMO cycles in HOLD lock_err=1, grant=0, pending req0 then served.
REQ-038 Missing busy: tie tx_busy=0, req0 valid -> lock_err set 4 cycles after tx_int, FSM returns to IDLE after GAP.
REQ-039 Reset mid-frame: assert rstn low in WAIT_DONE with tx_busy=1 -> outputs reset values; no new tx_int until tx_busy falls.
